// File: rtl/stream_req_gen_if.sv
// Handshake bundle for stream_req_gen: stream-start config, credit return,
// request output toward the tag interface, and per-stream busy flags.
interface stream_req_gen_if #(
   parameter int unsigned addr_width = 64,
   parameter int unsigned nstrms     = 64,
   parameter int unsigned cnt_width  = 32
);
   localparam int unsigned nstrms_width = $clog2(nstrms);

   logic                    i_cfg_v;
   logic                    i_cfg_r;
   logic [nstrms_width-1:0] i_cfg_sid;
   logic [addr_width-1:0]   i_cfg_ea;
   logic [cnt_width-1:0]    i_cfg_ncl;
   logic                    i_crd_v;
   logic [nstrms_width-1:0] i_crd_sid;
   logic                    o_req_v;
   logic                    o_req_r;
   logic [nstrms_width-1:0] o_req_sid;
   logic [addr_width-1:0]   o_req_ea;
   logic [nstrms-1:0]       o_busy;

   modport slave (
      input  i_cfg_v, i_cfg_sid, i_cfg_ea, i_cfg_ncl, i_crd_v, i_crd_sid, o_req_r,
      output i_cfg_r, o_req_v, o_req_sid, o_req_ea, o_busy
   );

   modport master (
      output i_cfg_v, i_cfg_sid, i_cfg_ea, i_cfg_ncl, i_crd_v, i_crd_sid, o_req_r,
      input  i_cfg_r, o_req_v, o_req_sid, o_req_ea, o_busy
   );
endinterface

// File: rtl/stream_req_gen.sv
// Credit-based multi-stream cache-line request generator with a round-robin
// arbiter feeding a single-entry output register.
module stream_req_gen #(
   parameter int unsigned addr_width = 64,
   parameter int unsigned nstrms     = 64,
   parameter int unsigned strm_ncl   = 4,
   parameter int unsigned cnt_width  = 32,
   parameter int unsigned cl_bytes   = 128
) (
   input  logic            clk,
   input  logic            reset,
   stream_req_gen_if.slave bus
);
   localparam int unsigned nstrms_width = $clog2(nstrms);
   localparam int unsigned crd_width    = $clog2(strm_ncl + 1);
   localparam int unsigned cl_lsb       = $clog2(cl_bytes);
   localparam logic [crd_width-1:0] crd_max = crd_width'(strm_ncl);

   logic [addr_width-1:0]   ea_q  [nstrms];
   logic [addr_width-1:0]   ea_d  [nstrms];
   logic [cnt_width-1:0]    cnt_q [nstrms];
   logic [cnt_width-1:0]    cnt_d [nstrms];
   logic [crd_width-1:0]    crd_q [nstrms];
   logic [crd_width-1:0]    crd_d [nstrms];
   logic [nstrms_width-1:0] rr_q, rr_d;
   logic                    req_v_q, req_v_d;
   logic [nstrms_width-1:0] req_sid_q, req_sid_d;
   logic [addr_width-1:0]   req_ea_q, req_ea_d;

   logic [nstrms-1:0]       busy;
   logic [nstrms-1:0]       elig;
   logic                    cfg_hs;
   logic                    load_en;
   logic                    grant_v;
   logic [nstrms_width-1:0] grant_sid;
   logic [nstrms_width-1:0] idx;
   logic                    gnt_s;
   logic                    ret_s;

   always_comb begin
      busy = '0;
      elig = '0;
      for (int unsigned s = 0; s < nstrms; s++) begin
         busy[s] = (cnt_q[s] != '0);
         elig[s] = (cnt_q[s] != '0) && (crd_q[s] != '0);
      end
   end

   assign bus.i_cfg_r = ~busy[bus.i_cfg_sid];
   assign cfg_hs      = bus.i_cfg_v & ~busy[bus.i_cfg_sid];
   assign load_en     = ~req_v_q | bus.o_req_r;

   // Scan starting just above the last winner so every eligible stream gets a turn.
   always_comb begin
      grant_v   = 1'b0;
      grant_sid = '0;
      idx       = '0;
      for (int unsigned k = 1; k <= nstrms; k++) begin
         idx = nstrms_width'((32'(rr_q) + k) % nstrms);
         if (!grant_v && elig[idx]) begin
            grant_v   = 1'b1;
            grant_sid = idx;
         end
      end
   end

   always_comb begin
      rr_d      = rr_q;
      req_v_d   = req_v_q;
      req_sid_d = req_sid_q;
      req_ea_d  = req_ea_q;
      gnt_s     = 1'b0;
      ret_s     = 1'b0;
      if (load_en) begin
         req_v_d = grant_v;
         if (grant_v) begin
            req_sid_d = grant_sid;
            req_ea_d  = ea_q[grant_sid];
            rr_d      = grant_sid;
         end
      end
      for (int unsigned s = 0; s < nstrms; s++) begin
         ea_d[s]  = ea_q[s];
         cnt_d[s] = cnt_q[s];
         crd_d[s] = crd_q[s];
         gnt_s    = load_en && grant_v && (grant_sid == nstrms_width'(s));
         ret_s    = bus.i_crd_v && (bus.i_crd_sid == nstrms_width'(s));
         // A cfg needs cnt == 0 and a grant needs cnt != 0, so they never collide.
         if (cfg_hs && (bus.i_cfg_sid == nstrms_width'(s))) begin
            ea_d[s]  = {bus.i_cfg_ea[addr_width-1:cl_lsb], {cl_lsb{1'b0}}};
            cnt_d[s] = bus.i_cfg_ncl;
         end
         if (gnt_s) begin
            ea_d[s]  = ea_q[s] + addr_width'(cl_bytes);
            cnt_d[s] = cnt_q[s] - cnt_width'(1);
         end
         // Saturate the return first, then consume: full + return + grant nets max-1.
         if (ret_s && (crd_q[s] != crd_max)) crd_d[s] = crd_q[s] + crd_width'(1);
         if (gnt_s) crd_d[s] = crd_d[s] - crd_width'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned s = 0; s < nstrms; s++) begin
            ea_q[s]  <= '0;
            cnt_q[s] <= '0;
            crd_q[s] <= crd_max;
         end
         rr_q      <= nstrms_width'(nstrms - 1);
         req_v_q   <= 1'b0;
         req_sid_q <= '0;
         req_ea_q  <= '0;
      end else begin
         for (int unsigned s = 0; s < nstrms; s++) begin
            ea_q[s]  <= ea_d[s];
            cnt_q[s] <= cnt_d[s];
            crd_q[s] <= crd_d[s];
         end
         rr_q      <= rr_d;
         req_v_q   <= req_v_d;
         req_sid_q <= req_sid_d;
         req_ea_q  <= req_ea_d;
      end
   end

   assign bus.o_req_v   = req_v_q;
   assign bus.o_req_sid = req_sid_q;
   assign bus.o_req_ea  = req_ea_q;
   assign bus.o_busy    = busy;
endmodule
